// File: rtl/restoring_div_ctrl.sv
// 8-bit unsigned restoring divider controller: one trial subtraction per clock,
// start/done handshake, registered quotient/remainder/div-by-zero results.

module cla_adder8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c0_i,
    output logic [7:0] s_o,
    output logic       cout_o
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c[0] = c0_i;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s_o    = p ^ c[7:0];
    assign cout_o = c[8];
endmodule

module restoring_div_ctrl #(
    parameter logic [7:0] DIV0_QUOT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] dvs_q, dvs_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quotient_q, quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [8:0] shifted;
    logic [7:0] diff;
    logic       cout;
    logic       ge;

    // Trial subtraction: shifted remainder minus divisor as A + ~D + 1.
    assign shifted = {rem_q, quo_q[7]};
    cla_adder8 u_adder (
        .a_i    (shifted[7:0]),
        .b_i    (~dvs_q),
        .c0_i   (1'b1),
        .s_o    (diff),
        .cout_o (cout)
    );
    // A set 9th bit means the shifted remainder already exceeds any 8-bit divisor.
    assign ge = shifted[8] | cout;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path can infer a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    quo_d = dividend;
                    rem_d = 8'd0;
                    cnt_d = 3'd0;
                    if (divisor == 8'd0) begin
                        state_d     = DONE;
                        quotient_d  = DIV0_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ge) begin
                    rem_d = diff;
                    quo_d = {quo_q[6:0], 1'b1};
                end else begin
                    rem_d = shifted[7:0];
                    quo_d = {quo_q[6:0], 1'b0};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d     = DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= 8'd0;
            quo_q       <= 8'd0;
            dvs_q       <= 8'd0;
            cnt_q       <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl: directed boundary cases plus
// randomized operations against a cycle-level behavioural model.

module tb_restoring_div_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       ready, busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    restoring_div_ctrl #(.DIV0_QUOT(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles left in the run, a done flag, and the held results.
    int         m_wait = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_q = 8'd0, m_r = 8'd0, p_q = 8'd0, p_r = 8'd0;
    logic       m_z = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0;
            m_done <= 1'b0;
            m_q    <= 8'd0;
            m_r    <= 8'd0;
            m_z    <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_z    <= 1'b0;
            end
        end else if (start) begin
            if (divisor == 8'd0) begin
                m_done <= 1'b1;
                m_q    <= 8'hFF;
                m_r    <= dividend;
                m_z    <= 1'b1;
            end else begin
                m_wait <= 8;
                p_q    <= dividend / divisor;
                p_r    <= dividend % divisor;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cycle_compare",
                  {12'd0, ready, busy, done, quotient, remainder, div_by_zero},
                  {12'd0, (!m_done && m_wait == 0), (m_wait > 0), m_done, m_q, m_r, m_z});
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int poke_at, input string tag);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, ready, 1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        n = 1;
        while (!done && n < 20) begin
            if (n == poke_at) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, (b == 8'd0) ? 1 : 9);
        check({tag, "_result"}, {15'd0, quotient, remainder, div_by_zero}, {15'd0, eq, er, ez});
        if (b != 8'd0) begin
            check({tag, "_identity"},
                  ((int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b)), 1);
        end
        @(negedge clk);
        check({tag, "_pulse"}, {done, ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] a, b;
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {ready, busy, done, quotient, remainder, div_by_zero}, 20'h80000);

        run_op(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 0, "d200_7");
        run_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0, "d255_1");
        run_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0, "d255_255");
        run_op(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0, "d5_9");
        run_op(8'd128, 8'd200, 8'd0,   8'd128, 1'b0, 0, "d128_200");
        run_op(8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 0, "d255_128");
        run_op(8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 0, "div0");
        run_op(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 0, "d9_3");
        run_op(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 3, "poke");
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {ready, busy, done, quotient, remainder, div_by_zero}, 20'h80000);
        @(negedge clk);
        #3 rst = 1'b0;
        run_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 0, "after_reset");

        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, a / b, a % b, 1'b0, ($urandom_range(0, 3) == 0) ? 2 : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
